// File: rtl/grey_pkg.sv
// grey_pkg: shared coefficients, entry width and FSM states for the greyscale stream packer
package grey_pkg;
    localparam int COEF_R  = 77;
    localparam int COEF_G  = 150;
    localparam int COEF_B  = 29;
    localparam int ROUND   = 128;
    localparam int ENTRY_W = 10;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;
endpackage

// File: rtl/grey_fifo.sv
// grey_fifo: synchronous show-ahead FIFO; a push while full is taken when a pop frees the slot
module grey_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                       axi_clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge axi_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/grey_stream_packer.sv
// grey_stream_packer: RGB to greyscale pipeline with frame/row tagging, FIFO buffering and overflow flag
module grey_stream_packer import grey_pkg::*; #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        axi_clk,
    input  logic        reset,
    input  logic        i_pixel_valid,
    input  logic [23:0] i_rgb_data,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        o_frame_done,
    output logic        o_overflow,
    output logic        o_busy
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state, state_nx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic accept, x_end, frame_end, pop, full, empty;
    logic s1_valid, s1_user, s1_last, s2_valid;
    logic [15:0] s1_r, s1_g, s1_b;
    logic [ENTRY_W-1:0] s2_entry, head;
    logic [CW-1:0] count;
    assign accept    = i_pixel_valid && (state == IDLE || state == ACTIVE);
    assign x_end     = x == XW'(IMG_W - 1);
    assign frame_end = x_end && y == YW'(IMG_H - 1);
    assign pop       = m_tvalid && m_tready;
    assign m_tvalid  = !empty;
    assign {m_tuser, m_tlast, m_tdata} = empty ? '0 : head;
    assign o_frame_done = state == DONE;
    assign o_busy       = state != IDLE;
    always_ff @(posedge axi_clk) begin
        if (reset || state == DONE) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            x <= x_end ? '0 : x + 1'b1;
            if (x_end) y <= y + 1'b1;
        end
    end
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
        end
    end
    // Datapath registers are qualified by the valids, so they need no reset
    always_ff @(posedge axi_clk) begin
        s1_r     <= 16'(COEF_R) * 16'(i_rgb_data[7:0]);
        s1_g     <= 16'(COEF_G) * 16'(i_rgb_data[15:8]);
        s1_b     <= 16'(COEF_B) * 16'(i_rgb_data[23:16]);
        s1_user  <= x == '0 && y == '0;
        s1_last  <= x_end;
        s2_entry <= {s1_user, s1_last, 8'((s1_r + s1_g + s1_b + 16'(ROUND)) >> 8)};
    end
    always_ff @(posedge axi_clk) begin
        if (reset) o_overflow <= 1'b0;
        else if ((s2_valid && full && !pop) || (i_pixel_valid && !accept)) o_overflow <= 1'b1;
    end
    always_ff @(posedge axi_clk) begin
        state <= reset ? IDLE : state_nx;
    end
    // Leave DRAIN on the edge that pops the final beat so the done pulse follows it directly
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = frame_end ? DRAIN : ACTIVE;
            ACTIVE:  if (accept && frame_end) state_nx = DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid && (empty || (count == CW'(1) && pop))) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    grey_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .axi_clk (axi_clk),
        .reset   (reset),
        .push    (s2_valid),
        .pop     (pop),
        .wdata   (s2_entry),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );
endmodule

// File: tb/tb_grey_stream_packer.sv
// tb_grey_stream_packer: directed checks of latency, tagging, overflow, drain and reset behaviour
module tb_grey_stream_packer;
    logic axi_clk = 1'b0, reset = 1'b1, i_pixel_valid = 1'b0, m_tready = 1'b0;
    logic [23:0] i_rgb_data = '0;
    logic [7:0] m_tdata;
    logic m_tvalid, m_tlast, m_tuser, o_frame_done, o_overflow, o_busy;
    int total = 0, bad = 0, done_cnt = 0;
    logic [9:0] beats[$];
    logic [23:0] rgb_tab[6] = '{24'hFFFFFF, 24'h0000FF, 24'h000000, 24'h00FF00, 24'hFF0000, 24'h808080};
    logic [7:0] grey_tab[6] = '{8'd255, 8'd77, 8'd0, 8'd149, 8'd29, 8'd128};

    grey_stream_packer dut (
        .axi_clk      (axi_clk),
        .reset        (reset),
        .i_pixel_valid(i_pixel_valid),
        .i_rgb_data   (i_rgb_data),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser),
        .o_frame_done (o_frame_done),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    always #5 axi_clk = ~axi_clk;

    always @(negedge axi_clk) begin
        if (m_tvalid && m_tready) beats.push_back({m_tuser, m_tlast, m_tdata});
        if (o_frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge axi_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        settle(2);
        reset = 1'b0;
    endtask

    task automatic px(input logic [23:0] rgb);
        i_pixel_valid = 1'b1;
        i_rgb_data = rgb;
        settle(1);
        i_pixel_valid = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int k = 0; k < n; k++) px(rgb_tab[k % 6]);
    endtask

    // Beat j carries pixel j, or pixel j+skip_n once past skip_at dropped pixels
    task automatic check_beats(input string tag, input int n, input int skip_at, input int skip_n);
        int ed = 0, eu = 0, el = 0, p;
        chk({tag, "_beats"}, beats.size(), n);
        foreach (beats[j]) begin
            p = j < skip_at ? j : j + skip_n;
            if (beats[j][7:0] != grey_tab[p % 6]) ed++;
            if (beats[j][9] != (p == 0)) eu++;
            if (beats[j][8] != (p % 64 == 63)) el++;
        end
        chk({tag, "_data_err"}, ed, 0);
        chk({tag, "_user_err"}, eu, 0);
        chk({tag, "_last_err"}, el, 0);
    endtask

    initial begin
        do_reset();
        @(negedge axi_clk);
        chk("rst_stream", {m_tvalid, m_tlast, m_tuser, m_tdata}, 0);
        chk("rst_status", {o_frame_done, o_overflow, o_busy}, 0);

        for (int i = 0; i < 3; i++) begin
            do_reset();
            m_tready = 1'b1;
            px(rgb_tab[i]);
            @(negedge axi_clk);
            chk("lat_e0", m_tvalid, 0);
            @(negedge axi_clk);
            chk("lat_e1", m_tvalid, 0);
            @(negedge axi_clk);
            chk("lat_e2", m_tvalid, 1);
            chk("single_data", m_tdata, grey_tab[i]);
            chk("single_tags", {m_tuser, m_tlast}, 2);
        end

        do_reset();
        m_tready = 1'b1;
        beats.delete();
        done_cnt = 0;
        stream(4096);
        settle(40);
        check_beats("frame", 4096, 4096, 0);
        chk("frame_done", done_cnt, 1);
        chk("frame_ovf", o_overflow, 0);
        chk("frame_busy", o_busy, 0);

        do_reset();
        m_tready = 1'b0;
        beats.delete();
        done_cnt = 0;
        fork
            stream(4096);
            begin
                settle(40);
                m_tready = 1'b1;
            end
            begin
                repeat (30) @(negedge axi_clk);
                chk("stall_head", {m_tvalid, m_tuser, m_tdata}, {1'b1, 1'b1, grey_tab[0]});
            end
        join
        settle(60);
        check_beats("stall", 4074, 16, 22);
        chk("stall_ovf", o_overflow, 1);
        chk("stall_done", done_cnt, 1);

        do_reset();
        m_tready = 1'b0;
        beats.delete();
        done_cnt = 0;
        fork
            begin
                stream(16);
                for (int i = 16; i < 216; i++) begin
                    settle(1);
                    px(rgb_tab[i % 6]);
                end
            end
            begin
                settle(19);
                for (int i = 0; i < 200; i++) begin
                    m_tready = 1'b1;
                    settle(1);
                    m_tready = 1'b0;
                    settle(1);
                end
            end
        join
        m_tready = 1'b1;
        settle(30);
        check_beats("full_pp", 216, 216, 0);
        chk("full_pp_ovf", o_overflow, 0);
        chk("full_pp_done", done_cnt, 0);

        do_reset();
        m_tready = 1'b1;
        beats.delete();
        done_cnt = 0;
        stream(4096);
        i_pixel_valid = 1'b1;
        settle(2);
        i_pixel_valid = 1'b0;
        settle(40);
        check_beats("drain", 4096, 4096, 0);
        chk("drain_ovf", o_overflow, 1);
        chk("drain_done", done_cnt, 1);

        do_reset();
        m_tready = 1'b1;
        done_cnt = 0;
        stream(1000);
        reset = 1'b1;
        settle(1);
        reset = 1'b0;
        chk("rst_mid_nodone", done_cnt, 0);
        beats.delete();
        @(negedge axi_clk);
        chk("rst_mid_out", {m_tvalid, o_busy}, 0);
        settle(1);
        stream(4096);
        settle(40);
        check_beats("after_rst", 4096, 4096, 0);
        chk("after_rst_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
